// File: rtl/store_drain.sv
// store_drain: drain end of the store FIFO.
// Buffers committed stores in a DEPTH-entry FIFO and issues them in order to
// the data-memory write port over a req/ack handshake. Each store leaves with
// a word-aligned address, lane-replicated data and byte strobes.
// Optional build macro: STORE_HAZARD_CHECK_EN enables the exact load/store
// alias comparators. Without it, load_hazard is the conservative !drained.
module store_drain #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        store_push,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_val,
    input  logic [1:0]  store_size,
    output logic        storefifo_full,
    output logic        drained,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] load_addr,
    output logic        load_hazard
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    // FIFO storage
    logic [31:0]      r_fifo_addr [DEPTH];
    logic [31:0]      r_fifo_val  [DEPTH];
    logic [1:0]       r_fifo_size [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic [0:0]       r_state;

    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_wstrb;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_head_addr;
    logic [31:0]      w_head_val;
    logic [1:0]       w_head_size;
    logic             w_hazard;
    logic             w_load_addr_unused;

    // Byte strobes for a store of the given size at the given byte offset.
    // Size 3 never arrives and is treated as a word.
    function automatic logic [3:0] f_lane_strb(input logic [1:0] lo, input logic [1:0] size);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << lo;
            2'd1:    strb = lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate the right-justified store data across every lane it may land in.
    function automatic logic [31:0] f_lane_data(input logic [31:0] val, input logic [1:0] size);
        logic [31:0] data;
        case (size)
            2'd0:    data = {4{val[7:0]}};
            2'd1:    data = {2{val[15:0]}};
            default: data = val;
        endcase
        return data;
    endfunction

    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // A push while full is dropped even when a pop frees a slot the same cycle.
    assign w_push = store_push && !w_full;

    // Pop whenever the output registers are free: idle, or the current request is acked.
    assign w_pop  = !w_empty && ((r_state == S_IDLE) || mem_ack);

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_val  = r_fifo_val[r_rd_ptr];
    assign w_head_size = r_fifo_size[r_rd_ptr];

    // Write accepted stores into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= store_addr;
            r_fifo_val[r_wr_ptr]  <= store_val;
            r_fifo_size[r_wr_ptr] <= store_size;
        end
    end

    // Pointers, occupancy and issue FSM, with the head formatted into the output registers on pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_state     <= S_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
                r_mem_addr  <= {w_head_addr[31:2], 2'b00};
                r_mem_wdata <= f_lane_data(w_head_val, w_head_size);
                r_mem_wstrb <= f_lane_strb(w_head_addr[1:0], w_head_size);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    if (mem_ack && w_empty) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef STORE_HAZARD_CHECK_EN
    logic [PTR_W-1:0] w_idx;

    // Compare the load word address against every valid entry and the in-flight request.
    always_comb begin
        w_hazard = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PTR_W'(i);
            if (((PTR_W+1)'(i) < r_count) && (r_fifo_addr[w_idx][31:2] == load_addr[31:2])) begin
                w_hazard = 1'b1;
            end
        end
        if ((r_state == S_REQ) && (r_mem_addr[31:2] == load_addr[31:2])) begin
            w_hazard = 1'b1;
        end
    end

    assign w_load_addr_unused = ^load_addr[1:0];
`else
    // Without comparators any pending store is assumed to alias.
    assign w_hazard           = !drained;
    assign w_load_addr_unused = ^load_addr;
`endif

    assign storefifo_full = w_full;
    assign drained        = w_empty && (r_state == S_IDLE);
    assign mem_req        = (r_state == S_REQ);
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign mem_wstrb      = r_mem_wstrb;
    assign load_hazard    = w_hazard;

endmodule
